// File: rtl/pipe_adder_pkg.sv
// Shared constants for the segmented, pipelined add/sub unit.
package pipe_adder_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SEGS  = 2;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SADD = 2'b10;
  localparam logic [1:0] OP_SSUB = 2'b11;

  // Subtraction is A + ~B + 1, so bit 0 of op selects inversion and carry-in.
  function automatic logic opIsSub(input logic [1:0] opc);
    return opc[0];
  endfunction

endpackage

// File: rtl/add_seg.sv
// One carry-chain segment: adds two operand slices plus carry-in and registers the result.
module add_seg #(
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             carry_i,
  output logic [SEG_W-1:0] sum_o,
  output logic             carry_o
);

  logic [SEG_W:0] total_d;
  logic [SEG_W:0] total_q;

  assign total_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, carry_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
    end else if (en_i) begin
      total_q <= total_d;
    end
  end

  assign sum_o   = total_q[SEG_W-1:0];
  assign carry_o = total_q[SEG_W];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor with optional saturation; the carry chain is split into
// SEGS registered segments, LSB segment first, with valid/ready flow control.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEGS  = DEF_SEGS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   SUM,
  output logic             sat
);

  localparam int SEGS_SAFE = (SEGS < 1) ? 1 : SEGS;
  localparam int SEG_W     = WIDTH / SEGS_SAFE;
  localparam int LAST      = SEGS_SAFE - 1;

  if (SEGS < 1 || WIDTH < 4 || (WIDTH % SEGS_SAFE) != 0 || SEGS_SAFE > WIDTH / 2) begin : gBadParams
    $error("pipe_adder: illegal WIDTH=%0d / SEGS=%0d", WIDTH, SEGS);
  end

  logic             advance;

  // Stage inputs: the segment to add next always sits at the LSB of stA/stB.
  logic [WIDTH-1:0] stA     [SEGS_SAFE];
  logic [WIDTH-1:0] stB     [SEGS_SAFE];
  logic [WIDTH-1:0] stLow   [SEGS_SAFE];
  logic             stCin   [SEGS_SAFE];
  logic             stValid [SEGS_SAFE];
  logic [1:0]       stOp    [SEGS_SAFE];

  logic             vld_q   [SEGS_SAFE];
  logic [1:0]       op_q    [SEGS_SAFE];
  logic [WIDTH-1:0] remA_q  [SEGS_SAFE];
  logic [WIDTH-1:0] remB_q  [SEGS_SAFE];
  logic [WIDTH-1:0] low_q   [SEGS_SAFE];
  logic [SEG_W-1:0] segSum  [SEGS_SAFE];
  logic             segCarry[SEGS_SAFE];
  logic [WIDTH-1:0] partial [SEGS_SAFE];

  assign out_valid = vld_q[LAST];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  for (genvar k = 0; k < SEGS_SAFE; k++) begin : gStage
    if (k == 0) begin : gFirst
      assign stA[k]     = A;
      assign stB[k]     = opIsSub(op) ? ~B : B;
      assign stCin[k]   = opIsSub(op);
      assign stValid[k] = in_valid;
      assign stOp[k]    = op;
      assign stLow[k]   = '0;
    end else begin : gNext
      assign stA[k]     = remA_q[k-1];
      assign stB[k]     = remB_q[k-1];
      assign stCin[k]   = segCarry[k-1];
      assign stValid[k] = vld_q[k-1];
      assign stOp[k]    = op_q[k-1];
      assign stLow[k]   = partial[k-1];
    end

    add_seg #(
      .SEG_W(SEG_W)
    ) uSeg (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (advance),
      .a_i    (stA[k][SEG_W-1:0]),
      .b_i    (stB[k][SEG_W-1:0]),
      .carry_i(stCin[k]),
      .sum_o  (segSum[k]),
      .carry_o(segCarry[k])
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[k]  <= 1'b0;
        op_q[k]   <= OP_ADD;
        remA_q[k] <= '0;
        remB_q[k] <= '0;
        low_q[k]  <= '0;
      end else if (advance) begin
        vld_q[k]  <= stValid[k];
        op_q[k]   <= stOp[k];
        remA_q[k] <= stA[k] >> SEG_W;
        remB_q[k] <= stB[k] >> SEG_W;
        low_q[k]  <= stLow[k];
      end
    end

    assign partial[k] = low_q[k] | (WIDTH'(segSum[k]) << (k * SEG_W));
  end

  // Saturation is decided only here, from the final carry (borrow = !carry for sub).
  always_comb begin
    SUM = {segCarry[LAST], partial[LAST]};
    sat = 1'b0;
    case (op_q[LAST])
      OP_ADD: begin
        SUM = {segCarry[LAST], partial[LAST]};
      end
      OP_SUB: begin
        SUM = {~segCarry[LAST], partial[LAST]};
      end
      OP_SADD: begin
        if (segCarry[LAST]) begin
          SUM = {1'b0, {WIDTH{1'b1}}};
          sat = 1'b1;
        end else begin
          SUM = {1'b0, partial[LAST]};
        end
      end
      default: begin
        if (!segCarry[LAST]) begin
          SUM = '0;
          sat = 1'b1;
        end else begin
          SUM = {1'b0, partial[LAST]};
        end
      end
    endcase
  end

endmodule
